control_sequencer: RTL

- Decode/sequencing stage directly upstream of the bus-control decoder.
- Accepts 8-bit instruction bytes from fetch over a valid/ready handshake.
- Emits one registered bus-control word per cycle: MainAssert, MainLoad, LhsAssert, RhsAssert, plus alu_op and const_data.
- Single-cycle instructions issue back-to-back. Multi-byte and memory instructions are sequenced by an FSM with a memory-ack stall and timeout.

---
 rtl/control_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Decode/sequencing stage feeding the bus-control decoder. Accepts instruction
// bytes over valid/ready and emits one registered control word per cycle.
// Multi-cycle instructions (LDI and STORE) and HALT are sequenced by a small FSM.
module control_sequencer #(
  parameter int STORE_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic [7:0] instr_data,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       mem_ack,
  output logic [3:0] MainAssert,
  output logic [3:0] MainLoad,
  output logic [1:0] LhsAssert,
  output logic [1:0] RhsAssert,
  output logic [1:0] alu_op,
  output logic [7:0] const_data,
  output logic       illegal_op,
  output logic       bus_error,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_DECODE     = 3'd0,
    S_IMM        = 3'd1,
    S_IMM_MOVE   = 3'd2,
    S_STORE_WAIT = 3'd3,
    S_HALT       = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ldi_dst, ldi_dst_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [8:0] cnt_inc;
  logic       xfer;

  logic [3:0] main_assert_nxt, main_load_nxt;
  logic [1:0] lhs_nxt, rhs_nxt, alu_op_nxt;
  logic [7:0] const_nxt;
  logic       illegal_nxt, bus_error_nxt, halted_nxt;

  // Ready depends on state only so fetch never sees a combinational loop through valid.
  assign instr_ready = (state == S_DECODE) || (state == S_IMM);
  assign xfer        = instr_valid && instr_ready;
  assign cnt_inc     = {1'b0, cnt} + 9'd1;

  // Next-state and next control word; every word defaults to all-zero control.
  always_comb begin
    state_nxt       = state;
    ldi_dst_nxt     = ldi_dst;
    cnt_nxt         = cnt;
    main_assert_nxt = 4'd0;
    main_load_nxt   = 4'd0;
    lhs_nxt         = 2'd0;
    rhs_nxt         = 2'd0;
    alu_op_nxt      = 2'd0;
    const_nxt       = const_data;
    illegal_nxt     = 1'b0;
    bus_error_nxt   = 1'b0;
    halted_nxt      = halted;
    case (state)
      S_DECODE: begin
        if (xfer) begin
          casez (instr_data)
            8'b0011_1111: begin
              halted_nxt = 1'b1;
              state_nxt  = S_HALT;
            end
            8'b0000_????: begin
              // Same source and destination is a NOP: leave the word at zero.
              if (instr_data[3:2] != instr_data[1:0]) begin
                main_assert_nxt = {2'b00, instr_data[1:0]} + 4'd1;
                main_load_nxt   = {2'b00, instr_data[3:2]} + 4'd1;
              end
            end
            8'b01??_????: begin
              lhs_nxt         = instr_data[3:2];
              rhs_nxt         = instr_data[1:0];
              alu_op_nxt      = instr_data[5:4];
              main_assert_nxt = 4'd8;
              main_load_nxt   = {2'b00, instr_data[3:2]} + 4'd1;
            end
            8'b10??_0000: begin
              ldi_dst_nxt = instr_data[5:4];
              state_nxt   = S_IMM;
            end
            8'b11??_0000: begin
              main_assert_nxt = {2'b00, instr_data[5:4]} + 4'd1;
              main_load_nxt   = 4'd15;
              cnt_nxt         = 8'd0;
              state_nxt       = S_STORE_WAIT;
            end
            default: illegal_nxt = 1'b1;
          endcase
        end
      end
      S_IMM: begin
        if (xfer) begin
          main_load_nxt = 4'd5;
          const_nxt     = instr_data;
          state_nxt     = S_IMM_MOVE;
        end
      end
      S_IMM_MOVE: begin
        main_assert_nxt = 4'd5;
        main_load_nxt   = {2'b00, ldi_dst} + 4'd1;
        state_nxt       = S_DECODE;
      end
      S_STORE_WAIT: begin
        // Ack is checked first so a coincident timeout never raises bus_error.
        if (mem_ack) begin
          state_nxt = S_DECODE;
        end else if (cnt_inc >= 9'(STORE_TIMEOUT)) begin
          cnt_nxt       = cnt_inc[7:0];
          bus_error_nxt = 1'b1;
          state_nxt     = S_DECODE;
        end else begin
          cnt_nxt         = cnt_inc[7:0];
          main_assert_nxt = MainAssert;
          main_load_nxt   = MainLoad;
        end
      end
      S_HALT: begin
        halted_nxt = 1'b1;
      end
      default: state_nxt = S_DECODE;
    endcase
  end

  // State and registered control word; reset forces an all-zero word next cycle.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state      <= S_DECODE;
      ldi_dst    <= 2'd0;
      cnt        <= 8'd0;
      MainAssert <= 4'd0;
      MainLoad   <= 4'd0;
      LhsAssert  <= 2'd0;
      RhsAssert  <= 2'd0;
      alu_op     <= 2'd0;
      const_data <= 8'd0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      ldi_dst    <= ldi_dst_nxt;
      cnt        <= cnt_nxt;
      MainAssert <= main_assert_nxt;
      MainLoad   <= main_load_nxt;
      LhsAssert  <= lhs_nxt;
      RhsAssert  <= rhs_nxt;
      alu_op     <= alu_op_nxt;
      const_data <= const_nxt;
      illegal_op <= illegal_nxt;
      bus_error  <= bus_error_nxt;
      halted     <= halted_nxt;
    end
  end

endmodule
